// File: rtl/sap1_pkg.sv
// SAP-1 controller shared definitions: opcodes, T-state encodings
// and control-word bit positions used by controller, datapath and bench.
package sap1_pkg;

    localparam int OPCODE_W = 4;
    localparam int NUM_T    = 6;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    localparam logic [NUM_T-1:0] T_HALT = 6'b000000;
    localparam logic [NUM_T-1:0] T1     = 6'b000001;
    localparam logic [NUM_T-1:0] T2     = 6'b000010;
    localparam logic [NUM_T-1:0] T3     = 6'b000100;
    localparam logic [NUM_T-1:0] T4     = 6'b001000;
    localparam logic [NUM_T-1:0] T5     = 6'b010000;
    localparam logic [NUM_T-1:0] T6     = 6'b100000;

    localparam int CW_PC_INC   = 0;
    localparam int CW_PC_OUT   = 1;
    localparam int CW_MAR_LOAD = 2;
    localparam int CW_RAM_OUT  = 3;
    localparam int CW_IR_LOAD  = 4;
    localparam int CW_IR_OUT   = 5;
    localparam int CW_A_LOAD   = 6;
    localparam int CW_A_OUT    = 7;
    localparam int CW_B_LOAD   = 8;
    localparam int CW_ALU_SUB  = 9;
    localparam int CW_ALU_OUT  = 10;
    localparam int CW_OUT_LOAD = 11;
    localparam int CW_DEMUX    = 12;
    localparam int CW_W        = 13;

    typedef logic [CW_W-1:0] ctrl_word_t;

    // Single-bit control word, handy for building decode tables.
    function automatic ctrl_word_t cw_bit(input int idx);
        ctrl_word_t w;
        w = '0;
        w[idx] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/sap1_ctrl_if.sv
// Controller-to-datapath bundle: run/opcode in, T-state and
// every control strobe out. master = controller, slave = datapath.
interface sap1_ctrl_if;
    import sap1_pkg::*;

    logic                run;
    logic [OPCODE_W-1:0] opcode;
    logic [NUM_T-1:0]    t_state;
    logic                halted;
    logic                pc_inc;
    logic                pc_out;
    logic                mar_load;
    logic                ram_out;
    logic                ir_load;
    logic                ir_out;
    logic                a_load;
    logic                a_out;
    logic                b_load;
    logic                alu_sub;
    logic                alu_out;
    logic                out_load;
    logic                demux_sel;

    modport master (
        input  run, opcode,
        output t_state, halted,
        output pc_inc, pc_out, mar_load, ram_out,
        output ir_load, ir_out, a_load, a_out,
        output b_load, alu_sub, alu_out, out_load,
        output demux_sel
    );

    modport slave (
        output run, opcode,
        input  t_state, halted,
        input  pc_inc, pc_out, mar_load, ram_out,
        input  ir_load, ir_out, a_load, a_out,
        input  b_load, alu_sub, alu_out, out_load,
        input  demux_sel
    );

endinterface

// File: rtl/sap1_ring_counter.sv
// One-hot T1..T6 ring with run gating, HALT entry from T4
// and synchronous active-low reset back to T1.
module sap1_ring_counter
    import sap1_pkg::*;
#(
    parameter int W = NUM_T
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         run_i,
    input  logic         hlt_i,
    output logic [W-1:0] t_state_o,
    output logic         halted_o
);

    localparam logic [W-1:0] S_T1   = W'(1);
    localparam logic [W-1:0] S_T4   = W'(8);
    localparam logic [W-1:0] S_HALT = '0;

    logic [W-1:0] state_q, state_d;
    logic         halted_q, halted_d;

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (!halted_q && run_i) begin
            if (state_q == S_T4 && hlt_i) begin
                state_d  = S_HALT;
                halted_d = 1'b1;
            end else begin
                state_d = {state_q[W-2:0], state_q[W-1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q  <= S_T1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign t_state_o = state_q;
    assign halted_o  = halted_q;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: ring counter plus combinational
// decode of T-state and opcode into the per-cycle control word.
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int OPCODE_W_P = OPCODE_W,
    parameter int NUM_T_P    = NUM_T
) (
    input  logic          clk,
    input  logic          clr_n,
    sap1_ctrl_if.master   bus
);

    logic [OPCODE_W_P-1:0] op;
    logic [NUM_T_P-1:0]    t_q;
    logic                  halted;
    logic                  hlt_op;
    logic                  active;
    ctrl_word_t            raw_cw;
    ctrl_word_t            cw;

    assign op     = bus.opcode;
    assign hlt_op = (op == OP_HLT);

    sap1_ring_counter #(
        .W (NUM_T_P)
    ) u_ring (
        .clk       (clk),
        .clr_n     (clr_n),
        .run_i     (bus.run),
        .hlt_i     (hlt_op),
        .t_state_o (t_q),
        .halted_o  (halted)
    );

    always_comb begin
        raw_cw = '0;
        unique case (1'b1)
            t_q[0]: raw_cw = cw_bit(CW_PC_OUT)
                           | cw_bit(CW_MAR_LOAD);
            t_q[1]: raw_cw = cw_bit(CW_PC_INC);
            t_q[2]: raw_cw = cw_bit(CW_RAM_OUT)
                           | cw_bit(CW_IR_LOAD);
            t_q[3]: begin
                unique case (op)
                    OP_LDA, OP_ADD, OP_SUB:
                        raw_cw = cw_bit(CW_IR_OUT)
                               | cw_bit(CW_MAR_LOAD);
                    OP_OUT:
                        raw_cw = cw_bit(CW_A_OUT)
                               | cw_bit(CW_OUT_LOAD)
                               | cw_bit(CW_DEMUX);
                    default: raw_cw = '0;
                endcase
            end
            t_q[4]: begin
                unique case (op)
                    OP_LDA:
                        raw_cw = cw_bit(CW_RAM_OUT)
                               | cw_bit(CW_A_LOAD);
                    OP_ADD, OP_SUB:
                        raw_cw = cw_bit(CW_RAM_OUT)
                               | cw_bit(CW_B_LOAD);
                    default: raw_cw = '0;
                endcase
            end
            t_q[5]: begin
                unique case (op)
                    OP_ADD:
                        raw_cw = cw_bit(CW_ALU_OUT)
                               | cw_bit(CW_A_LOAD);
                    OP_SUB:
                        raw_cw = cw_bit(CW_ALU_OUT)
                               | cw_bit(CW_A_LOAD)
                               | cw_bit(CW_ALU_SUB);
                    default: raw_cw = '0;
                endcase
            end
            default: raw_cw = '0;
        endcase
    end

    // Pause, reset and HALT all silence every strobe.
    assign active = clr_n && bus.run && !halted;
    assign cw     = active ? raw_cw : '0;

    assign bus.t_state   = t_q;
    assign bus.halted    = halted;
    assign bus.pc_inc    = cw[CW_PC_INC];
    assign bus.pc_out    = cw[CW_PC_OUT];
    assign bus.mar_load  = cw[CW_MAR_LOAD];
    assign bus.ram_out   = cw[CW_RAM_OUT];
    assign bus.ir_load   = cw[CW_IR_LOAD];
    assign bus.ir_out    = cw[CW_IR_OUT];
    assign bus.a_load    = cw[CW_A_LOAD];
    assign bus.a_out     = cw[CW_A_OUT];
    assign bus.b_load    = cw[CW_B_LOAD];
    assign bus.alu_sub   = cw[CW_ALU_SUB];
    assign bus.alu_out   = cw[CW_ALU_OUT];
    assign bus.out_load  = cw[CW_OUT_LOAD];
    assign bus.demux_sel = cw[CW_DEMUX];

endmodule

// File: tb/tb_sap1_controller.sv
// Scoreboard bench for sap1_controller: directed scenarios plus
// random run/reset/opcode traffic against a step-number model.
module tb_sap1_controller;
    import sap1_pkg::*;

    logic clk = 1'b0;
    logic clr_n_r = 1'b0;
    logic run_r = 1'b0;
    logic [3:0] op_r = 4'h0;

    always #5 clk = ~clk;

    sap1_ctrl_if bus();

    assign bus.run    = run_r;
    assign bus.opcode = op_r;

    sap1_controller dut (
        .clk   (clk),
        .clr_n (clr_n_r),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0]  t;
        logic        h;
        logic [12:0] cw;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    int m_step = 1;
    bit m_halt = 1'b0;

    logic [12:0] obs;
    always_comb begin
        obs = '0;
        obs[CW_PC_INC]   = bus.pc_inc;
        obs[CW_PC_OUT]   = bus.pc_out;
        obs[CW_MAR_LOAD] = bus.mar_load;
        obs[CW_RAM_OUT]  = bus.ram_out;
        obs[CW_IR_LOAD]  = bus.ir_load;
        obs[CW_IR_OUT]   = bus.ir_out;
        obs[CW_A_LOAD]   = bus.a_load;
        obs[CW_A_OUT]    = bus.a_out;
        obs[CW_B_LOAD]   = bus.b_load;
        obs[CW_ALU_SUB]  = bus.alu_sub;
        obs[CW_ALU_OUT]  = bus.alu_out;
        obs[CW_OUT_LOAD] = bus.out_load;
        obs[CW_DEMUX]    = bus.demux_sel;
    end

    // Microcode table by step number (1..6) and opcode.
    function automatic logic [12:0] ref_cw(int step, logic [3:0] op);
        logic [12:0] w;
        w = '0;
        if (step == 1) begin
            w[CW_PC_OUT] = 1; w[CW_MAR_LOAD] = 1;
        end else if (step == 2) begin
            w[CW_PC_INC] = 1;
        end else if (step == 3) begin
            w[CW_RAM_OUT] = 1; w[CW_IR_LOAD] = 1;
        end else if (step == 4) begin
            if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
                w[CW_IR_OUT] = 1; w[CW_MAR_LOAD] = 1;
            end else if (op == 4'hE) begin
                w[CW_A_OUT] = 1; w[CW_OUT_LOAD] = 1; w[CW_DEMUX] = 1;
            end
        end else if (step == 5) begin
            if (op == 4'h0) begin
                w[CW_RAM_OUT] = 1; w[CW_A_LOAD] = 1;
            end else if (op == 4'h1 || op == 4'h2) begin
                w[CW_RAM_OUT] = 1; w[CW_B_LOAD] = 1;
            end
        end else if (step == 6) begin
            if (op == 4'h1 || op == 4'h2) begin
                w[CW_ALU_OUT] = 1; w[CW_A_LOAD] = 1;
                w[CW_ALU_SUB] = (op == 4'h2);
            end
        end
        return w;
    endfunction

    task automatic model_edge();
        if (!clr_n_r) begin
            m_step = 1;
            m_halt = 1'b0;
        end else if (!m_halt && run_r) begin
            if (m_step == 4 && op_r == 4'hF) m_halt = 1'b1;
            else m_step = (m_step == 6) ? 1 : m_step + 1;
        end
    endtask

    task automatic cyc(input logic r, input logic c, input logic [3:0] o);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        run_r = r;
        clr_n_r = c;
        op_r = o;
        e.h = m_halt;
        e.t = m_halt ? 6'd0 : 6'(1 << (m_step - 1));
        e.cw = (c && r && !m_halt) ? ref_cw(m_step, o) : 13'd0;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.t_state !== e.t) begin
                errors++;
                $display("FAIL t_state @%0t: got %h want %h",
                         $time, bus.t_state, e.t);
            end
            checks++;
            if (bus.halted !== e.h) begin
                errors++;
                $display("FAIL halted @%0t: got %b want %b",
                         $time, bus.halted, e.h);
            end
            checks++;
            if (obs !== e.cw) begin
                errors++;
                $display("FAIL ctrl_word @%0t: got %b want %b",
                         $time, obs, e.cw);
            end
            checks++;
            if ($countones({bus.pc_out, bus.ram_out, bus.ir_out,
                            bus.a_out, bus.alu_out}) > 1) begin
                errors++;
                $display("FAIL bus_drivers @%0t: got %b want <=1 hot",
                         $time, {bus.pc_out, bus.ram_out, bus.ir_out,
                                 bus.a_out, bus.alu_out});
            end
        end
    end

    initial begin
        // LDA with wrap
        cyc(1, 0, 4'h0);
        repeat (7) cyc(1, 1, 4'h0);
        // SUB then ADD
        cyc(1, 0, 4'h2);
        repeat (6) cyc(1, 1, 4'h2);
        cyc(1, 0, 4'h1);
        repeat (6) cyc(1, 1, 4'h1);
        // OUT x3
        cyc(1, 0, 4'hE);
        repeat (18) cyc(1, 1, 4'hE);
        // HLT, hold with run toggling, then reset out
        cyc(1, 0, 4'hF);
        repeat (5) cyc(1, 1, 4'hF);
        for (int i = 0; i < 20; i++)
            cyc(logic'(i % 2), 1, 4'($urandom_range(0, 15)));
        cyc(0, 0, 4'h0);
        cyc(1, 1, 4'h0);
        // Pause in T2
        cyc(1, 0, 4'h0);
        cyc(1, 1, 4'h0);
        repeat (5) cyc(0, 1, 4'h0);
        repeat (3) cyc(1, 1, 4'h0);
        // Reset during T5 of ADD
        cyc(1, 0, 4'h1);
        repeat (4) cyc(1, 1, 4'h1);
        cyc(1, 0, 4'h1);
        repeat (3) cyc(1, 1, 4'h1);
        // Undefined opcode
        cyc(1, 0, 4'h7);
        repeat (7) cyc(1, 1, 4'h7);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [3:0] o;
            int k;
            k = $urandom_range(0, 7);
            case (k)
                0: o = 4'h0;
                1: o = 4'h1;
                2: o = 4'h2;
                3: o = 4'hE;
                4: o = 4'hF;
                default: o = 4'($urandom_range(0, 15));
            endcase
            cyc(logic'($urandom_range(0, 9) < 8),
                logic'($urandom_range(0, 39) != 0), o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0",
                     q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sap1_controller.md
Name: sap1_controller

Overview:
- Control sequencer for the SAP-1 datapath.
- Runs a 6-state one-hot ring counter (T1–T6) and decodes the IR opcode nibble into the per-cycle control word.
- Drives the bus-routing select of the 8-bit demux that sits directly downstream, plus every load/enable strobe.
- Sits between the instruction register and the datapath; it is the sole source of control timing.

Parameters:
OPCODE_W, 4, width of the opcode field taken from IR[7:4]
NUM_T, 6, ring-counter length; 6 is the only supported value

Ports:
clk  input  1  system clock, all state updates on rising edge
clr_n  input  1  synchronous active-low reset
run  input  1  1 = sequencer advances; 0 = pause (state held, all strobes 0)
opcode  input  OPCODE_W  IR upper nibble; valid from T4 onward
t_state  output  6  one-hot current T-state (bit0 = T1); 0 in HALT
pc_inc  output  1  program counter increment
pc_out  output  1  PC drives bus
mar_load  output  1  MAR loads from bus
ram_out  output  1  RAM drives bus
ir_load  output  1  IR loads from bus
ir_out  output  1  IR low nibble drives bus
a_load  output  1  accumulator loads
a_out  output  1  accumulator drives bus
b_load  output  1  B register loads
alu_sub  output  1  ALU subtract (0 = add)
alu_out  output  1  ALU drives bus
out_load  output  1  output register loads
demux_sel  output  1  select to downstream demux: 0 = datapath side (out0), 1 = output port side (out1)
halted  output  1  1 while in HALT

Behaviour:
- Reset: clk and clr_n; reset is synchronous and active-low.
  - Any rising edge with clr_n=0 puts the state in T1 and clears halted. This holds even mid-instruction or while in HALT.
  - While clr_n=0, all strobes and demux_sel are forced to 0 combinationally.
  - After the reset edge: t_state=6'b000001, halted=0.
- State: registered one-hot ring T1→T2→…→T6→T1 with a separate HALT state. Advances one step per edge when run=1 and not halted.
- Control outputs are combinational decodes of the registered state plus opcode, so strobes are valid in the same cycle as t_state. Zero added latency.
- Fetch cycle, independent of opcode:
  - T1: pc_out, mar_load.
  - T2: pc_inc.
  - T3: ram_out, ir_load.
- Execute cycle. opcode is sampled combinationally in T4–T6; the IR updates at the edge ending T3.
  - LDA (4'h0): T4 ir_out+mar_load; T5 ram_out+a_load; T6 none.
  - ADD (4'h1): T4 ir_out+mar_load; T5 ram_out+b_load; T6 alu_out+a_load (alu_sub=0).
  - SUB (4'h2): as ADD, but T6 also asserts alu_sub.
  - OUT (4'hE): T4 a_out+out_load+demux_sel; T5, T6 none.
  - HLT (4'hF): T4 asserts no strobes; the next edge enters HALT instead of T5.
  - Any other opcode: NOP; T4–T6 assert no strobes.
- demux_sel is 1 only in OUT/T4; it is 0 in every other state.
- At most one bus driver (pc_out, ram_out, ir_out, a_out, alu_out) is asserted in any cycle. This is an invariant.
- run=0:
  - State holds.
  - All strobes and demux_sel are forced to 0, so no repeated pc_inc or loads.
  - Resuming with run=1 continues from the held T-state; that state's strobes reappear for exactly one cycle.
- HALT:
  - t_state=0, halted=1, all strobes 0.
  - run and opcode are ignored.
  - Only clr_n=0 exits, to T1.
- Simultaneous clr_n=0 and run=0: reset wins.
- Wrap: T6→T1 unconditionally when run=1.

Decomposition:
- Shared package sap1_pkg holds:
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT;
  - one-hot T-state constants T1..T6;
  - control-word bit-index constants, for reuse by datapath and bench.
- One natural sub-module: sap1_ring_counter. It owns the one-hot register, run gating, HALT entry and the synchronous active-low reset.
- Opcode decode stays in sap1_controller.

Test Plan:
- Reset then run=1 with opcode=4'h0 for 6 cycles → t_state sequence 01,02,04,08,10,20 (hex). Strobes as listed: T1 pc_out+mar_load, T2 pc_inc, T3 ram_out+ir_load, T4 ir_out+mar_load, T5 ram_out+a_load, T6 none. Then wrap to 01.
- opcode=4'h2 (SUB) → in T6 alu_out=a_load=alu_sub=1. Same sequence with opcode=4'h1 → alu_sub=0 in T6.
- opcode=4'hE (OUT) → in T4 a_out=out_load=demux_sel=1. demux_sel is 0 in every other cycle across 3 full instructions.
- opcode=4'hF (HLT) → after T4 the next edge gives halted=1, t_state=0, all strobes 0. Holds for 20 cycles with run toggling. clr_n=0 for one edge → t_state=01, halted=0.
- run dropped to 0 in T2 for 5 cycles → t_state stays 02, pc_inc=0 throughout. Raise run → pc_inc=1 for exactly one cycle, then T3.
- clr_n=0 asserted during T5 of ADD → next edge gives t_state=01, all strobes 0 during reset. Invariant check every cycle: at most one bus driver high; undefined opcode 4'h7 produces no strobes in T4–T6.
